uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Parameters
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: payload bits per frame; legal values are 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values are 1 or 2.

Interface
REQ-005 The block SHALL have port clk  input  1: system clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-007 The block SHALL have port send  input  1: level request to transmit data.
REQ-008 The block SHALL have port data  input  DATA_BITS: payload, sampled only at frame start.
REQ-009 The block SHALL have port tx  output  1: serial line, idle high.
REQ-010 The block SHALL have port busy  output  1: high while a frame is on the line.
REQ-011 The block SHALL have port done  output  1: single-cycle pulse at frame end.

Function
REQ-012 The block SHALL use the states IDLE, START, DATA, PAR, STOP and WAIT; undefined encodings SHALL go to IDLE on the next clock.
REQ-013 In IDLE, when send=1 at a clock edge, the block SHALL latch data into a shift register and enter START on that edge.
REQ-014 The block SHALL drive tx=0 during START.
REQ-015 During DATA, the block SHALL drive tx from the shift register, LSB first.
REQ-016 During PAR, the block SHALL drive tx with the parity bit.
REQ-017 During STOP, the block SHALL drive tx=1.
REQ-018 In IDLE and WAIT, the block SHALL drive tx=1.
REQ-019 Each bit SHALL occupy exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that clears on every bit boundary.
REQ-020 A bit counter SHALL advance the DATA state after each bit.
REQ-021 DATA SHALL exit after DATA_BITS bits: to PAR if PARITY!=0, otherwise to STOP.
REQ-022 PAR SHALL last 1 bit, then go to STOP.
REQ-023 STOP SHALL last STOP_BITS bits.
REQ-024 The parity bit SHALL be the XOR of the latched payload for even parity, and its inverse for odd parity.
REQ-025 The block SHALL drive busy=1 in START, DATA, PAR and STOP, and busy=0 otherwise.
REQ-026 busy SHALL rise the cycle after send is accepted.
REQ-027 The frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-028 On the clock edge that ends the last stop bit, the block SHALL pulse done=1 for one cycle and enter WAIT.
REQ-029 In WAIT, the block SHALL return to IDLE when send=0; while send stays high the block SHALL start no new frame.
REQ-030 Changes on data or send during a frame SHALL NOT affect the frame in progress.
REQ-031 When send=1 and the state returns to IDLE in the same cycle, no frame SHALL start until IDLE samples send=1.

Reset
REQ-032 While reset=1, the block SHALL force the state to IDLE, tx=1, busy=0 and done=0, and clear all counters and the shift register.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately and SHALL NOT produce a done pulse.
REQ-034 After reset deasserts, the block SHALL accept a new send on the first clock edge.

Verification
REQ-035 Scenario 1 (CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1): send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for 40 cycles; one done pulse.
REQ-036 Scenario 2 (PARITY=2): send 0x03 -> parity bit 0. With PARITY=1: send 0x03 -> parity bit 1. Frame is 44 cycles in both cases.
REQ-037 Scenario 3 (DATA_BITS=5, STOP_BITS=2): send 0x1F -> tx = 0,1,1,1,1,1,1,1; frame is 32 cycles.
REQ-038 Scenario 4: hold send high for 200 cycles -> exactly one frame, then WAIT; drop send for 1 cycle and raise it again -> a second frame starts.
REQ-039 Scenario 5: change data from 0xA5 to 0x00 during bit 2 -> serialized bits still match 0xA5.
REQ-040 Scenario 6: assert reset during data bit 3 -> tx=1 and busy=0 without waiting for a clock, no done pulse; after release, send 0x3C -> a correct full frame.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, 5..9 data bits LSB first,
// optional odd/even parity, one or two stop bits, registered outputs.
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 send,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST =
      BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY == 1);
   localparam logic       HAS_PAR   = (PARITY != 0);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      WAIT  = 3'd5
   } state_t;

   state_t               state;
   logic [BAUD_W-1:0]    baud;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 bit_end;

   assign bit_end = (baud == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               baud    <= '0;
               bit_cnt <= '0;
               if (send) begin
                  // Payload and parity are frozen here for the whole frame
                  shreg   <= data;
                  par_bit <= (^data) ^ ODD;
                  state   <= START;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud    <= '0;
                  bit_cnt <= '0;
                  state   <= DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud <= '0;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (HAS_PAR) begin
                        state <= PAR;
                        tx    <= par_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            PAR: begin
               if (bit_end) begin
                  baud    <= '0;
                  bit_cnt <= '0;
                  state   <= STOP;
                  tx      <= 1'b1;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  baud <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     state   <= WAIT;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            WAIT: begin
               // A held request must be released before the next frame
               tx   <= 1'b1;
               busy <= 1'b0;
               if (!send) state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               busy    <= 1'b0;
               baud    <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule
